// File: rtl/pmod_pattern_pkg.sv
// Shared types for the PMOD pattern generator: channel modes and one-shot FSM states.
// Pure declarations; no logic, no latency, no backpressure.
package pmod_pattern_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'b00,
        MODE_DIV   = 2'b01,
        MODE_PWM   = 2'b10,
        MODE_PULSE = 2'b11
    } mode_e;

    typedef enum logic {
        PS_IDLE   = 1'b0,
        PS_ACTIVE = 1'b1
    } pulse_state_e;

endpackage

// File: rtl/pmod_pattern_ch.sv
// One PMOD channel: mode mux over divider tap, PWM compare and triggered one-shot.
// Output registered, 1-cycle latency from cnt/cfg; free-running, no backpressure.
module pmod_pattern_ch
    import pmod_pattern_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TAP_W   = $clog2(CNT_W),
    parameter int DUTY_W  = 8,
    parameter int PULSE_W = 16
) (
    input  logic               clk200,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   cnt,
    input  logic               rise,
    input  mode_e              mode,
    input  logic [TAP_W-1:0]   tap,
    input  logic [DUTY_W-1:0]  duty,
    input  logic [PULSE_W-1:0] pulse_len,
    output logic               pmod_out,
    output logic               busy
);

    localparam int IDX_W = $clog2(CNT_W);

    logic [IDX_W-1:0]   tap_idx;
    logic               pwm_hit;
    pulse_state_e       state;
    pulse_state_e       state_nxt;
    logic [PULSE_W-1:0] remain;
    logic [PULSE_W-1:0] remain_nxt;
    logic               out_nxt;

    // Only tap codes that can name a bit beyond the counter need clamping.
    if ((1 << TAP_W) > CNT_W) begin : g_clamp
        always_comb begin
            tap_idx = (tap > TAP_W'(CNT_W - 1)) ? IDX_W'(CNT_W - 1) : tap[IDX_W-1:0];
        end
    end else begin : g_direct
        always_comb begin
            tap_idx = tap[IDX_W-1:0];
        end
    end

    always_comb begin
        pwm_hit = (cnt[DUTY_W-1:0] < duty);
    end

    always_comb begin
        state_nxt  = state;
        remain_nxt = remain;
        if (mode != MODE_PULSE) begin
            state_nxt  = PS_IDLE;
            remain_nxt = '0;
        end else begin
            case (state)
                PS_IDLE: begin
                    if (rise && (pulse_len != '0)) begin
                        state_nxt  = PS_ACTIVE;
                        remain_nxt = pulse_len - PULSE_W'(1);
                    end
                end
                PS_ACTIVE: begin
                    if (remain == '0) begin
                        state_nxt = PS_IDLE;
                    end else begin
                        remain_nxt = remain - PULSE_W'(1);
                    end
                end
                default: state_nxt = PS_IDLE;
            endcase
        end

        out_nxt = 1'b0;
        case (mode)
            MODE_OFF:   out_nxt = 1'b0;
            MODE_DIV:   out_nxt = cnt[tap_idx];
            MODE_PWM:   out_nxt = pwm_hit;
            MODE_PULSE: out_nxt = (state_nxt == PS_ACTIVE);
            default:    out_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk200 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= PS_IDLE;
            remain   <= '0;
            pmod_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            remain   <= remain_nxt;
            pmod_out <= out_nxt;
        end
    end

    assign busy = (state == PS_ACTIVE);

endmodule

// File: rtl/pmod_pattern_gen.sv
// PMOD pattern generator: shared counter, trigger sync/edge detect, heartbeat, N_CH channels.
// All outputs registered (1 cycle; trigger-to-pulse SYNC_STAGES+2 edges); no backpressure.
module pmod_pattern_gen
    import pmod_pattern_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 32,
    parameter int TAP_W       = $clog2(CNT_W),
    parameter int DUTY_W      = 8,
    parameter int PULSE_W     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk200,
    input  logic                     rst_n,
    input  logic [N_CH*MODE_W-1:0]   cfg_mode,
    input  logic [N_CH*TAP_W-1:0]    cfg_tap,
    input  logic [N_CH*DUTY_W-1:0]   cfg_duty,
    input  logic [PULSE_W-1:0]       cfg_pulse_len,
    input  logic                     trig_async,
    output logic [N_CH-1:0]          pmod_out,
    output logic [N_CH-1:0]          busy,
    output logic                     heartbeat
);

    logic [CNT_W-1:0]       cnt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   trig_prev;
    logic                   rise;

    // rise is registered so every channel sees a clean single-cycle strobe.
    always_ff @(posedge clk200 or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            sync      <= '0;
            trig_prev <= 1'b0;
            rise      <= 1'b0;
            heartbeat <= 1'b0;
        end else begin
            cnt       <= cnt + CNT_W'(1);
            sync      <= {sync[SYNC_STAGES-2:0], trig_async};
            trig_prev <= sync[SYNC_STAGES-1];
            rise      <= sync[SYNC_STAGES-1] & ~trig_prev;
            heartbeat <= cnt[CNT_W-1];
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pmod_pattern_ch #(
            .CNT_W   (CNT_W),
            .TAP_W   (TAP_W),
            .DUTY_W  (DUTY_W),
            .PULSE_W (PULSE_W)
        ) u_ch (
            .clk200    (clk200),
            .rst_n     (rst_n),
            .cnt       (cnt),
            .rise      (rise),
            .mode      (mode_e'(cfg_mode[MODE_W*i +: MODE_W])),
            .tap       (cfg_tap[TAP_W*i +: TAP_W]),
            .duty      (cfg_duty[DUTY_W*i +: DUTY_W]),
            .pulse_len (cfg_pulse_len),
            .pmod_out  (pmod_out[i]),
            .busy      (busy[i])
        );
    end

endmodule
